sparce_skip_unit: RTL and testbench

//  Parametrised SparCE skip engine between the pipeline and the sparce_pipeline_if.

---
 rtl/sparce_skip_unit.sv | 164 ++++++++++++++++
 tb/tb_sparce_skip_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sparce_skip_unit.sv
// rtl/sparce_skip_unit.sv - SparCE skip engine: sparsity value register, SASA table and skip lookup
// A fetch PC that hits a programmed entry whose condition registers are all zero redirects fetch.
module sparce_skip_unit #(
  parameter int          NUM_ENTRIES = 16,
  parameter int          NUM_CONDS   = 2,
  parameter logic [31:0] SASA_ADDR   = 32'h9000_1000,
  parameter int          OFF_W       = 12
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  input  logic        if_ex_enable,
  input  logic        wb_en,
  input  logic [4:0]  rd,
  input  logic [31:0] wb_data,
  input  logic        sasa_wen,
  input  logic [31:0] sasa_addr,
  input  logic [31:0] sasa_data,
  output logic        skipping,
  output logic [31:0] sparce_target
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic {IDLE, HAVE_PC} state_t;

  state_t             state, state_nxt;
  logic [31:0]        stage_pc;
  logic               stage_load;
  logic               commit;
  logic [IDX_W-1:0]   fill_ptr;

  logic [NUM_ENTRIES-1:0] ent_valid;
  logic [31:0]            ent_pc   [NUM_ENTRIES];
  logic [OFF_W-1:0]       ent_off  [NUM_ENTRIES];
  logic [4:0]             ent_cond [NUM_ENTRIES][NUM_CONDS];

  logic [31:0]        svr, svr_eff;

  logic               match_hit, lk_hit, conds_zero;
  logic [IDX_W-1:0]   match_idx, lk_idx, wr_idx;
  logic               cfg_valid;
  logic [OFF_W-1:0]   cfg_off;
  logic               unused_cfg;

  assign cfg_valid  = sasa_data[31];
  assign cfg_off    = sasa_data[30 -: OFF_W];
  assign unused_cfg = ^sasa_data;

  // Sparsity value register; x0 is always zero so its bit never changes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      svr <= '1;
    end else if (wb_en && rd != 5'd0) begin
      svr[rd] <= (wb_data == 32'd0);
    end
  end

  // Same-cycle writeback overrides the stored bit for the lookup.
  always_comb begin
    svr_eff = svr;
    if (wb_en && rd != 5'd0) svr_eff[rd] = (wb_data == 32'd0);
    svr_eff[0] = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      stage_pc <= '0;
    end else begin
      state <= state_nxt;
      if (stage_load) stage_pc <= {sasa_data[31:2], 2'b00};
    end
  end

  always_comb begin
    state_nxt  = state;
    stage_load = 1'b0;
    commit     = 1'b0;
    if (sasa_wen) begin
      case (state)
        IDLE: begin
          if (sasa_addr == SASA_ADDR) begin
            stage_load = 1'b1;
            state_nxt  = HAVE_PC;
          end
        end
        HAVE_PC: begin
          if (sasa_addr == SASA_ADDR + 32'd4) begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end else if (sasa_addr == SASA_ADDR) begin
            stage_load = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Descending scans so the lowest matching index is the one kept.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    lk_hit    = 1'b0;
    lk_idx    = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_pc[i] == stage_pc) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (ent_valid[i] && ent_pc[i] == pc) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  assign wr_idx = match_hit ? match_idx : fill_ptr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ent_valid <= '0;
      fill_ptr  <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_pc[i]  <= '0;
        ent_off[i] <= '0;
        for (int k = 0; k < NUM_CONDS; k++) ent_cond[i][k] <= '0;
      end
    end else if (commit) begin
      if (cfg_valid) begin
        ent_valid[wr_idx] <= 1'b1;
        ent_pc[wr_idx]    <= stage_pc;
        ent_off[wr_idx]   <= cfg_off;
        for (int k = 0; k < NUM_CONDS; k++) ent_cond[wr_idx][k] <= sasa_data[5*k +: 5];
        if (!match_hit) fill_ptr <= fill_ptr + IDX_W'(1);
      end else if (match_hit) begin
        ent_valid[match_idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    conds_zero = 1'b1;
    for (int k = 0; k < NUM_CONDS; k++) begin
      if (ent_cond[lk_idx][k] != 5'd0 && !svr_eff[ent_cond[lk_idx][k]]) conds_zero = 1'b0;
    end
  end

  // A zero offset would redirect to the same PC, so it never skips.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      skipping      <= 1'b0;
      sparce_target <= '0;
    end else if (if_ex_enable && !skipping && lk_hit && conds_zero &&
                 ent_off[lk_idx] != '0) begin
      skipping      <= 1'b1;
      sparce_target <= ent_pc[lk_idx] + {{(30-OFF_W){1'b0}}, ent_off[lk_idx], 2'b00};
    end else begin
      skipping <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sparce_skip_unit.sv
// tb/tb_sparce_skip_unit.sv - scoreboard bench for sparce_skip_unit
module tb_sparce_skip_unit;
  localparam logic [31:0] SA = 32'h9000_1000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pc;
  logic        if_ex_enable;
  logic        wb_en;
  logic [4:0]  rd;
  logic [31:0] wb_data;
  logic        sasa_wen;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic        skipping;
  logic [31:0] sparce_target;

  typedef struct packed {
    logic        skip;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  sparce_skip_unit dut (
    .CLK(CLK), .nRST(nRST), .pc(pc), .if_ex_enable(if_ex_enable),
    .wb_en(wb_en), .rd(rd), .wb_data(wb_data),
    .sasa_wen(sasa_wen), .sasa_addr(sasa_addr), .sasa_data(sasa_data),
    .skipping(skipping), .sparce_target(sparce_target)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] cfg(input logic v, input logic [11:0] off,
                                      input logic [4:0] c1, input logic [4:0] c0);
    return {v, off, 4'b0000, 5'd0, c1, c0};
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    sasa_wen = 1'b1; sasa_addr = a; sasa_data = d;
    tick();
    sasa_wen = 1'b0; sasa_addr = '0; sasa_data = '0;
  endtask

  task automatic program_entry(input logic [31:0] p, input logic [31:0] c);
    store(SA, p);
    store(SA + 32'd4, c);
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; rd = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] a, input logic en,
                        input logic es, input logic [31:0] et);
    exp_t e;
    pc = a; if_ex_enable = en;
    exp_q.push_back({es, et});
    tick();
    if_ex_enable = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_skip"}, {31'd0, skipping}, {31'd0, e.skip});
    if (e.skip) check({tag, "_target"}, sparce_target, e.target);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    nRST = 1'b0; pc = '0; if_ex_enable = 1'b0; wb_en = 1'b0; rd = '0; wb_data = '0;
    sasa_wen = 1'b0; sasa_addr = '0; sasa_data = '0;
    tick(); tick();
    nRST = 1'b1;
    check("rst_skip", {31'd0, skipping}, 32'd0);
    check("rst_target", sparce_target, 32'd0);
    check("rst_svr", dut.svr, 32'hFFFF_FFFF);
    tick();

    // basic skip, single-cycle pulse
    wb(5'd5, 32'd0);
    program_entry(32'h100, cfg(1'b1, 12'd4, 5'd0, 5'd5));
    lookup("t2_hit", 32'h100, 1'b1, 1'b1, 32'h110);
    lookup("t2_b2b", 32'h100, 1'b1, 1'b0, 32'h0);

    // writeback bypass both ways, x0 protected
    wb_en = 1'b1; rd = 5'd5; wb_data = 32'd7;
    lookup("t3_bypass_nz", 32'h100, 1'b1, 1'b0, 32'h0);
    wb_en = 1'b0;
    lookup("t3_nz", 32'h100, 1'b1, 1'b0, 32'h0);
    wb_en = 1'b1; rd = 5'd5; wb_data = 32'd0;
    lookup("t3_bypass_z", 32'h100, 1'b1, 1'b1, 32'h110);
    wb_en = 1'b0;
    tick();
    wb(5'd0, 32'd7);
    check("t3_svr0", {31'd0, dut.svr[0]}, 32'd1);

    // disabled pipeline: no skip, target holds
    lookup("t6_disabled", 32'h100, 1'b0, 1'b0, 32'h0);
    check("t6_hold", sparce_target, 32'h110);
    program_entry(32'h303, cfg(1'b1, 12'd0, 5'd0, 5'd0));
    lookup("off0", 32'h300, 1'b1, 1'b0, 32'h0);

    // table wrap and in-place overwrite
    do_reset();
    for (int i = 1; i <= 17; i++) program_entry(32'h100 * i, cfg(1'b1, 12'd4, 5'd0, 5'd0));
    lookup("t4_evicted", 32'h100, 1'b1, 1'b0, 32'h0);
    lookup("t4_last", 32'h1100, 1'b1, 1'b1, 32'h1110);
    tick();
    program_entry(32'h200, cfg(1'b1, 12'd8, 5'd0, 5'd0));
    lookup("t4_overwrite", 32'h200, 1'b1, 1'b1, 32'h220);
    tick();
    program_entry(32'h5000, cfg(1'b1, 12'd4, 5'd0, 5'd0));
    lookup("t4_ptr_evict", 32'h200, 1'b1, 1'b0, 32'h0);
    lookup("t4_ptr_keep", 32'h300, 1'b1, 1'b1, 32'h310);
    tick();
    lookup("t4_new", 32'h5000, 1'b1, 1'b1, 32'h5010);
    tick();
    program_entry(32'h300, cfg(1'b0, 12'd4, 5'd0, 5'd0));
    lookup("invalidate", 32'h300, 1'b1, 1'b0, 32'h0);

    // stray config word, reset drops staged PC
    do_reset();
    store(SA + 32'd4, cfg(1'b1, 12'd4, 5'd0, 5'd0));
    lookup("t5_idle_cfg", 32'h0, 1'b1, 1'b0, 32'h0);
    store(SA, 32'h700);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    store(SA + 32'd4, cfg(1'b1, 12'd4, 5'd0, 5'd0));
    lookup("t5_reset_drop", 32'h700, 1'b1, 1'b0, 32'h0);
    program_entry(32'h700, cfg(1'b1, 12'd4, 5'd0, 5'd0));
    lookup("t5_control", 32'h700, 1'b1, 1'b1, 32'h710);
    tick();

    // address wraparound
    program_entry(32'hFFFF_FFF0, cfg(1'b1, 12'd8, 5'd0, 5'd0));
    lookup("t6_wrap", 32'hFFFF_FFF0, 1'b1, 1'b1, 32'h0000_0010);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
